digital_trigger_detect: RTL
===========================

Name: digital_trigger_detect

Overview:
Trigger qualifier that sits directly downstream of digital_decimation in the digital acquisition path. It consumes the decimated sample stream and evaluates a masked pattern or edge condition. It emits a single-cycle trigger pulse that drives the acquisition trigger output. Holdoff and single-shot/auto re-arm are handled here, so the capture logic only sees qualified triggers.

Parameters:
NUM_SIGNALS, 8, width of the digital sample bus (1..32)
HOLDOFF_WIDTH, 16, width of the holdoff counter in samples

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  qualifies in; one decimated sample per asserted cycle
in  input  NUM_SIGNALS  decimated digital sample
arm  input  1  pulse: latch config and start arming (honoured only in IDLE)
disarm  input  1  pulse: abort to IDLE from any state
mode  input  2  00 level match, 01 match entry, 10 match exit, 11 any masked change
trig_mask  input  NUM_SIGNALS  1 = channel participates
trig_value  input  NUM_SIGNALS  required level per masked channel
holdoff  input  HOLDOFF_WIDTH  samples ignored after a trigger before re-arm
single_shot  input  1  1 = stop after first trigger; 0 = auto re-arm
trigger  output  1  one-cycle pulse per qualified trigger
armed  output  1  high in ARMED state
holding  output  1  high in HOLDOFF state
done  output  1  sticky; set on single-shot trigger, cleared by next accepted arm

Behaviour:
- Reset: state IDLE; trigger, armed, holding and done are 0; prev sample register and holdoff counter cleared.
- Config latch: mode, trig_mask, trig_value, holdoff and single_shot are captured on an accepted arm and held until the next accepted arm. Input changes while armed have no effect.
- Combinational terms on the current sample, using the latched config:
  - m = ((in ^ value) & mask) == 0
  - m_prev = the same term on the previous valid sample
  - chg = ((in ^ prev) & mask) != 0
- Hit per mode: 00 m; 01 m & !m_prev; 10 !m & m_prev; 11 chg.
- prev updates on every in_valid cycle in every state except IDLE.
- States:
  - IDLE: an accepted arm clears done and moves to PRIME.
  - PRIME: the first in_valid sample loads prev only; no evaluation. Next state ARMED. This exists so edge modes have a defined history.
  - ARMED: on in_valid with hit, pulse trigger the next cycle (registered, latency 1 clk from the sample).
    - single_shot=1: go to IDLE and set done.
    - single_shot=0 with holdoff=0: stay in ARMED; every qualifying sample can trigger.
    - single_shot=0 with holdoff>0: load counter=holdoff and go to HOLDOFF.
  - HOLDOFF: decrement the counter on each in_valid. The sample that takes the counter to 0 goes to ARMED and is itself not evaluated. Exactly holdoff samples are ignored.
- Cycles with in_valid=0 change no state, counter or prev register.
- disarm takes priority over arm and over a simultaneous hit. The next state is IDLE and no trigger pulse is issued for that cycle's sample. done is unchanged.
- arm while not in IDLE is ignored and config is not re-latched.
- mask=0 behaviour:
  - mode 00 triggers on every evaluated sample.
  - modes 01, 10 and 11 never trigger.
- trigger never asserts for two consecutive cycles unless in_valid is high on consecutive cycles with holdoff=0 and the condition is met on each.
- rst mid-operation returns to the reset values on the next edge. Any pending trigger pulse is suppressed.

Test Plan:
- Level, single-shot: mask=8'h0F, value=8'h05, mode=00, single_shot=1. Samples 00, 05 (in PRIME), 03, 15 → trigger exactly once, one cycle after the 8'h15 sample; the PRIME 05 is ignored. State returns to IDLE with done=1; a later 8'h05 produces no trigger.
- Edge entry/exit: mask=8'h01, value=8'h01. mode=01 on samples 00, 00, 01, 01, 00, 01 → two pulses, after each 00→01 transition. mode=10 on the same stream → one pulse, after the 01→00 transition.
- Holdoff: mode=00, mask=0, holdoff=3, single_shot=0, 10 consecutive valid samples after PRIME. Pulses follow samples 1, 5 and 9; holding is high during samples 2–4 and 6–8.
- Gapped valid: repeat the holdoff case with in_valid alternating 1/0 → same sample-indexed pulses at doubled cycle spacing; counter and prev are frozen on gaps.
- Priority: in ARMED with a hit sample, assert disarm and arm in the same cycle → no trigger pulse, state IDLE, config unchanged. Arming during HOLDOFF is ignored.
- Reset mid-holdoff: assert rst while the counter is 2 → next cycle all outputs are 0 and state is IDLE. A fresh arm restarts from PRIME.

Source files
------------

// File: rtl/digital_trigger_detect.sv
// Trigger qualifier for the decimated digital sample stream.
// Evaluates a masked level/edge/change condition against a latched
// configuration, issues a registered one-cycle trigger pulse, and manages
// single-shot / auto re-arm with an optional holdoff in samples.
module digital_trigger_detect #(
  parameter int NUM_SIGNALS   = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_SIGNALS-1:0]   in,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic [1:0]               mode,
  input  logic [NUM_SIGNALS-1:0]   trig_mask,
  input  logic [NUM_SIGNALS-1:0]   trig_value,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                     single_shot,
  output logic                     trigger,
  output logic                     armed,
  output logic                     holding,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_ARMED = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_ENTRY = 2'b01;
  localparam logic [1:0] MODE_EXIT  = 2'b10;
  localparam logic [1:0] MODE_CHG   = 2'b11;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [NUM_SIGNALS-1:0]   mask_q, mask_d;
  logic [NUM_SIGNALS-1:0]   value_q, value_d;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
  logic                     single_q, single_d;
  logic [NUM_SIGNALS-1:0]   prev_q, prev_d;
  logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
  logic                     trigger_q, trigger_d;
  logic                     done_q, done_d;

  logic m, m_prev, chg, hit, fire, arm_ok, hold_last;

  // Match terms on the current sample and on the previous valid sample,
  // always against the latched configuration.
  always_comb begin
    m      = ((in ^ value_q) & mask_q) == '0;
    m_prev = ((prev_q ^ value_q) & mask_q) == '0;
    chg    = ((in ^ prev_q) & mask_q) != '0;
    hit    = 1'b0;
    unique case (mode_q)
      MODE_LEVEL: hit = m;
      MODE_ENTRY: hit = m & ~m_prev;
      MODE_EXIT:  hit = ~m & m_prev;
      MODE_CHG:   hit = chg;
      default:    hit = 1'b0;
    endcase
    // disarm wins over a simultaneous hit
    fire      = (state_q == S_ARMED) & in_valid & hit & ~disarm;
    arm_ok    = (state_q == S_IDLE) & arm & ~disarm;
    hold_last = (cnt_q == HOLDOFF_WIDTH'(1));
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      holdoff_q <= '0;
      single_q  <= 1'b0;
      prev_q    <= '0;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      holdoff_q <= holdoff_d;
      single_q  <= single_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; gap cycles (in_valid=0) never advance the FSM.
  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (arm) state_d = S_PRIME;
        S_PRIME: if (in_valid) state_d = S_ARMED;
        S_ARMED: begin
          if (fire) begin
            if (single_q)              state_d = S_IDLE;
            else if (holdoff_q != '0)  state_d = S_HOLD;
            else                       state_d = S_ARMED;
          end
        end
        S_HOLD:  if (in_valid && hold_last) state_d = S_ARMED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Config latch, history, holdoff counter, trigger pulse and done flag.
  always_comb begin
    mode_d    = mode_q;
    mask_d    = mask_q;
    value_d   = value_q;
    holdoff_d = holdoff_q;
    single_d  = single_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    trigger_d = fire;
    done_d    = done_q;

    if (arm_ok) begin
      mode_d    = mode;
      mask_d    = trig_mask;
      value_d   = trig_value;
      holdoff_d = holdoff;
      single_d  = single_shot;
      done_d    = 1'b0;
    end

    // History tracks every valid sample once armed; PRIME uses it to seed
    // the edge modes.
    if (in_valid && state_q != S_IDLE) prev_d = in;

    if (fire && !single_q && holdoff_q != '0) cnt_d = holdoff_q;
    if (state_q == S_HOLD && in_valid && !disarm) cnt_d = cnt_q - HOLDOFF_WIDTH'(1);

    if (fire && single_q) done_d = 1'b1;
  end

  // Status outputs decoded from state and flops.
  always_comb begin
    trigger = trigger_q;
    armed   = (state_q == S_ARMED);
    holding = (state_q == S_HOLD);
    done    = done_q;
  end

endmodule
